ser_bitstream_tx: RTL
=====================

Name: ser_bitstream_tx

Overview:
- Parallel-to-serial converter that feeds the serial-pattern detector stage. It drives the detector's single-bit input, one bit per clock.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first (or LSB-first) on x.
- Back-to-back words produce a gapless bitstream, and an optional hold input stretches bit-times.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.
- IDLE_LEVEL, 0, value driven on x when no word is being shifted.

Ports:
- CLK  input  1  clock, all state on rising edge.
- RESET  input  1  asynchronous, active-low reset; 0 = reset asserted.
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  din holds a valid word.
- din_ready  output  1  block accepts din on this edge when din_valid=1.
- hold  input  1  freeze shifting for this cycle.
- x  output  1  serial bit, registered; connects to the detector's x.
- x_valid  output  1  registered; 1 while x carries a word bit.
- busy  output  1  registered; 1 while in SHIFT.

Behaviour:
- Reset (RESET=0, async):
  - state=IDLE, shift register=0, bit counter=0.
  - x=IDLE_LEVEL, x_valid=0, busy=0.
  - Reset mid-word aborts the word; no remaining bits are ever emitted.
- States:
  - IDLE: no word in flight.
  - SHIFT: word in flight; counter cnt runs 0..WIDTH-1 and indexes the bit currently on x.
- din_ready is combinational: 1 in IDLE, or in SHIFT when cnt==WIDTH-1 and hold=0. It is 0 otherwise, and 0 during reset.
- Accept occurs on an edge where din_valid=1 and din_ready=1.
- Latency: the first bit of an accepted word appears on x in the cycle after the accepting edge.
- IDLE -> SHIFT on accept:
  - load shift register from din, cnt=0.
  - x = first bit (din[WIDTH-1] if MSB_FIRST, else din[0]).
  - x_valid=1, busy=1.
- SHIFT, hold=1: all registers frozen. x, x_valid and cnt keep their values, so the current bit-time is extended.
- SHIFT, hold=0, cnt<WIDTH-1: shift one position, x = next bit, cnt+1.
- SHIFT, hold=0, cnt==WIDTH-1:
  - if accept: reload from din, cnt=0, stay in SHIFT. This gives zero bubble; the bitstream is continuous across words.
  - else: go to IDLE, x=IDLE_LEVEL, x_valid=0, busy=0.
- hold in IDLE: no effect. Accept still allowed.
- din and din_valid changes while din_ready=0 are ignored; no buffering beyond the single shift register.
- Each word occupies exactly WIDTH bit-times with hold=0, i.e. exactly WIDTH clock cycles of x_valid=1.
- Counter width: ceil(log2(WIDTH)) bits. It never exceeds WIDTH-1, and wrap-around to 0 occurs only on reload.

Decomposition:
- Shared header of constants: state encodings ST_IDLE=1'b0 and ST_SHIFT=1'b1, plus the default WIDTH. The detector stage and its bench reuse the same header.
- No sub-module needed. The shift register, counter and FSM fit in one module, roughly 120-160 lines.

Test Plan:
- Single word, MSB_FIRST=1, din=8'hD0, one-cycle din_valid -> x = 1,1,0,1,0,0,0,0 on the 8 cycles after accept. x_valid=1 for exactly those 8 cycles, then x=0 and busy=0. A downstream detector's y rises one cycle after the 4th bit.
- Back-to-back, din=8'hB5 then 8'h6C with din_valid held high -> din_ready=1 in the 8th bit-cycle. 16 contiguous x bits 10110101_01101100 with no x_valid gap.
- Hold: hold=1 for 3 cycles starting at bit index 2 of 8'hF0 -> bit 2 (value 1) stays on x for 4 cycles, cnt stays frozen. The total word spans 11 cycles, and din_ready=0 throughout the hold.
- Reset mid-word: assert RESET=0 asynchronously after bit 3 of 8'hAA -> x=0, x_valid=0 and busy=0 immediately, without a clock edge. After release, only a newly accepted word is transmitted.
- LSB_FIRST: MSB_FIRST=0, WIDTH=4, din=4'b1011 -> x = 1,1,0,1, then idle.
- Idle level and backpressure: IDLE_LEVEL=1 -> x=1 after reset and between words. din_valid asserted while busy with cnt<WIDTH-1 is not accepted; the bench checks that din is sampled only on the din_ready edge.

Source files
------------

// File: rtl/ser_bitstream_tx_pkg.sv
// Shared constants for the serial transmitter and the pattern-detector stage it feeds.
// Holds the state encodings and the default word width.
package ser_bitstream_tx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/ser_bitstream_tx.sv
// Parallel-to-serial converter: takes WIDTH-bit words over valid/ready and emits one bit per clock on x.
// Words sent back to back form a gapless stream, and hold stretches the current bit-time.
module ser_bitstream_tx
  import ser_bitstream_tx_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             hold,
  output logic             x,
  output logic             x_valid,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q, busy_d;
  logic             accept;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // The bit on x always sits at the outgoing end of shreg, so advancing exposes the next one.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Ready is held low while reset is asserted so no word can be taken as reset releases.
  assign din_ready = RESET && ((state_q == ST_IDLE) || ((cnt_q == CNT_LAST) && !hold));
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    x_valid_d = x_valid_q;
    busy_d    = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_SHIFT;
          shreg_d   = din;
          cnt_d     = '0;
          x_d       = first_bit(din);
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!hold) begin
          if (cnt_q != CNT_LAST) begin
            shreg_d = advance(shreg_q);
            x_d     = first_bit(advance(shreg_q));
            cnt_d   = cnt_q + 1'b1;
          end else if (accept) begin
            shreg_d = din;
            cnt_d   = '0;
            x_d     = first_bit(din);
          end else begin
            state_d   = ST_IDLE;
            shreg_d   = '0;
            cnt_d     = '0;
            x_d       = IDLE_LEVEL;
            x_valid_d = 1'b0;
            busy_d    = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      x_q       <= IDLE_LEVEL;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;

endmodule
